// File: rtl/uart_pkt_ctrl_pkg.sv
// Shared types and constants for the UART packet controller.
// Holds the frame FSM encoding and checksum helper.
package uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HI,
      S_LO,
      S_CHK
   } state_e;

   localparam int         TIMEOUT_CYC_DEF = 104160;
   localparam int         FRAME_LEN       = 4;
   localparam logic [7:0] CHK_TARGET      = 8'hFF;

   function automatic logic chk_ok(
      input logic [7:0] sum,
      input logic [7:0] b
   );
      logic [7:0] s;
      s = sum + b;
      return s == CHK_TARGET;
   endfunction

endpackage

// File: rtl/uart_pkt_ctrl_if.sv
// Byte-in / frame-out bundle between UART receiver, host and the
// packet controller.
interface uart_pkt_ctrl_if;

   logic        byte_rdy;
   logic [7:0]  rx_byte;
   logic        clr_byte_rdy;
   logic        clr_cmd_rdy;
   logic [7:0]  cmd;
   logic [15:0] data;
   logic        cmd_rdy;
   logic        frm_err;
   logic [7:0]  err_cnt;

   modport master (
      output byte_rdy,
      output rx_byte,
      output clr_cmd_rdy,
      input  clr_byte_rdy,
      input  cmd,
      input  data,
      input  cmd_rdy,
      input  frm_err,
      input  err_cnt
   );

   modport slave (
      input  byte_rdy,
      input  rx_byte,
      input  clr_cmd_rdy,
      output clr_byte_rdy,
      output cmd,
      output data,
      output cmd_rdy,
      output frm_err,
      output err_cnt
   );

endinterface

// File: rtl/uart_pkt_ctrl_timer.sv
// Inter-byte timeout counter: clear has priority, counts while enabled,
// flags expiry when the count reaches LIMIT-1.
module frm_timer #(
   parameter int LIMIT = 104160,
   parameter int W     = 17
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i & (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/uart_pkt_ctrl.sv
// Assembles 4-byte CMD/HI/LO/CHK frames from a UART receiver,
// validates the checksum and presents the last good frame to the host.
module uart_pkt_ctrl
   import uart_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input logic            clk,
   input logic            rst,
   uart_pkt_ctrl_if.slave bus
);

   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   state_e      state_q, state_d;
   logic        guard_q, guard_d;
   logic        consume;
   logic        expire;
   logic        timeout;
   logic        chk_good;
   logic        frm_valid;
   logic        bad_chk;
   logic [7:0]  sum_q, sum_d;
   logic [7:0]  cmd_sh_q, cmd_sh_d;
   logic [7:0]  hi_sh_q, hi_sh_d;
   logic [7:0]  lo_sh_q, lo_sh_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [15:0] data_q, data_d;
   logic        rdy_q, rdy_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;

   // guard_q blocks a second consume while byte_rdy is still falling
   assign consume   = bus.byte_rdy & ~guard_q & ~rst;
   assign timeout   = expire & ~consume;
   assign chk_good  = chk_ok(sum_q, bus.rx_byte);
   assign frm_valid = (state_q == S_CHK) & consume & chk_good;
   assign bad_chk   = (state_q == S_CHK) & consume & ~chk_good;

   frm_timer #(
      .LIMIT (TIMEOUT_CYC),
      .W     (TW)
   ) u_tmr (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (consume | (state_q == S_IDLE)),
      .en_i     (state_q != S_IDLE),
      .expire_o (expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (consume) state_d = S_HI;
         S_HI: begin
            if (consume)      state_d = S_LO;
            else if (timeout) state_d = S_IDLE;
         end
         S_LO: begin
            if (consume)      state_d = S_CHK;
            else if (timeout) state_d = S_IDLE;
         end
         S_CHK: begin
            if (consume | timeout) state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      bus.clr_byte_rdy = consume;
   end

   always_comb begin
      guard_d  = consume;
      sum_d    = sum_q;
      cmd_sh_d = cmd_sh_q;
      hi_sh_d  = hi_sh_q;
      lo_sh_d  = lo_sh_q;
      if (consume) begin
         unique case (state_q)
            S_IDLE: begin
               sum_d    = bus.rx_byte;
               cmd_sh_d = bus.rx_byte;
            end
            S_HI: begin
               sum_d   = sum_q + bus.rx_byte;
               hi_sh_d = bus.rx_byte;
            end
            S_LO: begin
               sum_d   = sum_q + bus.rx_byte;
               lo_sh_d = bus.rx_byte;
            end
            S_CHK: sum_d = sum_q + bus.rx_byte;
         endcase
      end
   end

   always_comb begin
      cmd_d  = cmd_q;
      data_d = data_q;
      rdy_d  = rdy_q;
      // a completing frame outranks any clear in the same cycle
      if (frm_valid) begin
         cmd_d  = cmd_sh_q;
         data_d = {hi_sh_q, lo_sh_q};
         rdy_d  = 1'b1;
      end else if (bus.clr_cmd_rdy |
                   (consume & (state_q == S_IDLE))) begin
         rdy_d = 1'b0;
      end
      err_d = bad_chk | timeout;
      cnt_d = cnt_q;
      if (err_d && cnt_q != 8'hFF) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         guard_q  <= 1'b0;
         sum_q    <= '0;
         cmd_sh_q <= '0;
         hi_sh_q  <= '0;
         lo_sh_q  <= '0;
         cmd_q    <= '0;
         data_q   <= '0;
         rdy_q    <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         guard_q  <= guard_d;
         sum_q    <= sum_d;
         cmd_sh_q <= cmd_sh_d;
         hi_sh_q  <= hi_sh_d;
         lo_sh_q  <= lo_sh_d;
         cmd_q    <= cmd_d;
         data_q   <= data_d;
         rdy_q    <= rdy_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.cmd     = cmd_q;
   assign bus.data    = data_q;
   assign bus.cmd_rdy = rdy_q;
   assign bus.frm_err = err_q;
   assign bus.err_cnt = cnt_q;

endmodule

// File: doc/uart_pkt_ctrl.md
UART_PKT_CTRL -- requirements
Module: uart_pkt_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 104160, inter-byte timeout in clk cycles (4 byte times at 19200 baud, 50 MHz).
REQ-002 clk  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 byte_rdy  input  1  level from UART receiver; a received byte is waiting.
REQ-005 rx_byte  input  8  received byte; valid while byte_rdy high.
REQ-006 clr_byte_rdy  output  1  one-cycle consume strobe to UART receiver, combinational from state and byte_rdy.
REQ-007 clr_cmd_rdy  input  1  host acknowledge; clears cmd_rdy.
REQ-008 cmd  output  8  command byte of last valid frame, registered.
REQ-009 data  output  16  payload of last valid frame, {hi,lo}, registered.
REQ-010 cmd_rdy  output  1  valid frame available; level, registered.
REQ-011 frm_err  output  1  one-cycle pulse on checksum failure or timeout.
REQ-012 err_cnt  output  8  saturating count of frm_err pulses.

Function
REQ-013 Frame = 4 bytes in order: CMD, DATA_HI, DATA_LO, CHK; valid iff (CMD+HI+LO+CHK) mod 256 == 8'hFF.
REQ-014 FSM states: IDLE, HI, LO, CHK; IDLE->HI->LO->CHK advance only on a consumed byte; CHK->IDLE on consumed byte.
REQ-015 A byte is consumed in the cycle byte_rdy=1; clr_byte_rdy=1 that same cycle; byte captured at that clock edge.
REQ-016 After a consume, no further byte is consumed in the next cycle (guard against byte_rdy not yet deasserted).
REQ-017 Running 8-bit sum: loaded with CMD in IDLE, accumulates HI, LO, CHK; wrap-around mod 256.
REQ-018 On CHK consume with valid sum: cmd/data updated and cmd_rdy=1 on the next edge (latency 1 cycle after CHK consume).
REQ-019 On CHK consume with invalid sum: cmd/data/cmd_rdy unchanged, frm_err pulses next cycle, FSM to IDLE.
REQ-020 cmd_rdy cleared by clr_cmd_rdy or by CMD consume in IDLE; if set and clear coincide, set wins.
REQ-021 Timeout counter: zeroed on every consume and in IDLE; increments in HI/LO/CHK; reaching TIMEOUT_CYC-1 -> frm_err pulse, FSM to IDLE, partial frame discarded.
REQ-022 If timeout and consume coincide, consume wins; no error.
REQ-023 err_cnt increments per frm_err pulse, saturates at 8'hFF, no wrap.
REQ-024 cmd/data outputs hold last valid frame across errors and new partial frames.

Reset
REQ-025 On rst=1 at a clock edge: FSM=IDLE, cmd=8'h00, data=16'h0000, cmd_rdy=0, frm_err=0, err_cnt=0, sum=0, timeout counter=0.
REQ-026 clr_byte_rdy=0 while rst=1.
REQ-027 rst mid-frame discards partial frame; first byte after reset release is treated as CMD.

Structure
REQ-028 Shared package uart_pkg holds the FSM state enum, default TIMEOUT_CYC, frame length and checksum target 8'hFF.
REQ-029 One sub-module, frm_timer (clear/enable/expire counter), is natural; everything else stays in uart_pkt_ctrl.

Verification
REQ-030 Bytes 05,12,34,B4 -> cmd=05, data=1234, cmd_rdy=1 one cycle after 4th consume; frm_err never pulses.
REQ-031 Bytes 05,12,34,B5 -> frm_err single pulse, err_cnt=1, cmd_rdy stays 0, next frame 01,00,00,FE accepted.
REQ-032 Bytes 05,12 then idle TIMEOUT_CYC cycles -> frm_err pulse, FSM IDLE; next 4 valid bytes form a fresh frame.
REQ-033 byte_rdy held high 2 cycles per byte -> exactly one consume per byte (clr_byte_rdy pulses once).
REQ-034 clr_cmd_rdy asserted in the same cycle as a valid frame completes -> cmd_rdy=1; rst asserted after HI byte -> all outputs at reset values.
REQ-035 300 consecutive bad-checksum frames -> err_cnt saturates at FF.
